// File: rtl/spi_slave_gen_pkg.sv
// Shared types for the generic SPI slave: FSM state encoding, read-path phases
// and the two-bit command encoding carried at the top of every frame.
package spi_slave_gen_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    DONE      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_RX    = 2'd0,
    PH_WAIT  = 2'd1,
    PH_SHIFT = 2'd2
  } rd_phase_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_gen_shift_out.sv
// MISO serialiser: load drives the MSB on the following cycle, then one bit per
// cycle for DATA_W cycles; done is high while the final bit is on the line.
module spi_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              active;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
      miso   <= 1'b0;
    end else if (load) begin
      miso   <= data[DATA_W-1];
      shreg  <= {data[DATA_W-2:0], 1'b0};
      cnt    <= CW'(DATA_W-1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
        miso   <= 1'b0;
      end else begin
        miso  <= shreg[DATA_W-1];
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end
    end
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/spi_slave_gen_sva.sv
// Protocol assertions for spi_slave_gen, attached to its exported state,
// strobes and MISO.
module spi_slave_gen_sva
  import spi_slave_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  input logic [2:0]        cs,
  input logic              rx_valid,
  input logic [DATA_W+1:0] rx_data,
  input logic              MISO,
  input logic              frame_abort,
  input logic              tx_timeout
);

  a_cs_legal: assert property (@(posedge clk) disable iff (rst) cs <= 3'd5);

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({rx_valid, frame_abort, tx_timeout}));

  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (rst)
    rx_valid |=> !rx_valid);

  a_rx_known: assert property (@(posedge clk) disable iff (rst)
    rx_valid |-> !$isunknown(rx_data));

  a_miso_quiet: assert property (@(posedge clk) disable iff (rst)
    (cs != 3'(READ_DATA)) |-> !MISO);

  a_rd_data_cmd: assert property (@(posedge clk) disable iff (rst)
    (rx_valid && cs == 3'(READ_DATA)) |-> (rx_data[DATA_W+1 -: 2] == CMD_RD_DATA));

  a_wr_cmd: assert property (@(posedge clk) disable iff (rst)
    (rx_valid && (rx_data[DATA_W+1 -: 2] == CMD_WR_ADDR ||
                  rx_data[DATA_W+1 -: 2] == CMD_WR_DATA)) |-> (cs == 3'(DONE)));

  a_abort_idle: assert property (@(posedge clk) disable iff (rst)
    frame_abort |-> (cs == 3'(IDLE)));

  a_timeout_done: assert property (@(posedge clk) disable iff (rst)
    tx_timeout |-> (cs == 3'(DONE) && !MISO));

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front end for the RAM subsystem: command+payload deserialiser,
// read-data handshake with timeout, and MISO serialisation via spi_shift_out.
//
// state     | meaning
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling cmd MSB to pick the frame type
// WRITE     | receiving write-address / write-data frame
// READ_ADD  | receiving read-address frame
// READ_DATA | receiving read-data frame, then tx wait, then MISO shift
// DONE      | frame finished, waiting for SS_n high
module spi_slave_gen
  import spi_slave_gen_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int TX_TIMEOUT = 16,
  localparam int CNT_W      = $clog2(DATA_W+2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_abort,
  output logic              tx_timeout,
  output logic [2:0]        cs
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int TMR_W   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W-1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TX_TIMEOUT-1);

  state_e             state;
  rd_phase_e          phase;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               rd_addr_seen;
  logic               tx_load;
  logic               tx_clear;
  logic               tx_done;

  assign tx_load  = (state == READ_DATA) && (phase == PH_WAIT) && !SS_n && tx_valid;
  assign tx_clear = (state == READ_DATA) && (phase == PH_SHIFT) && SS_n;
  assign cs       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      shreg        <= '0;
      bit_cnt      <= '0;
      tmr          <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_abort  <= 1'b0;
      tx_timeout   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      tx_timeout  <= 1'b0;
      case (state)
        IDLE: if (!SS_n) state <= CHK_CMD;
        CHK_CMD: begin
          if (SS_n) begin
            state <= IDLE;
          end else begin
            shreg   <= FRAME_W'(MOSI);
            bit_cnt <= CNT_W'(1);
            phase   <= PH_RX;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          // SS_n high before completion always aborts, whatever the phase
          if (SS_n) begin
            state       <= IDLE;
            frame_abort <= 1'b1;
          end else begin
            case (phase)
              PH_RX: begin
                shreg <= {shreg[FRAME_W-2:0], MOSI};
                if (bit_cnt == LAST_BIT) begin
                  rx_data  <= {shreg[FRAME_W-2:0], MOSI};
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  if (state == READ_DATA) begin
                    phase <= PH_WAIT;
                    tmr   <= TMR_LOAD;
                  end else begin
                    state <= DONE;
                    if (state == READ_ADD) rd_addr_seen <= 1'b1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              PH_WAIT: begin
                if (tx_valid) begin
                  phase <= PH_SHIFT;
                end else if (tmr == '0) begin
                  tx_timeout   <= 1'b1;
                  rd_addr_seen <= 1'b0;
                  state        <= DONE;
                end else begin
                  tmr <= tmr - 1'b1;
                end
              end
              PH_SHIFT: begin
                if (tx_done) begin
                  rd_addr_seen <= 1'b0;
                  state        <= DONE;
                end
              end
              default: phase <= PH_RX;
            endcase
          end
        end
        DONE: if (SS_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  spi_shift_out #(.DATA_W(DATA_W)) u_shift_out (
    .clk   (clk),
    .rst   (rst),
    .load  (tx_load),
    .clear (tx_clear),
    .data  (tx_data),
    .miso  (MISO),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: stimulus queues expected responses, a
// monitor compares them whenever the DUT strobes or drives MISO.
module tb_spi_slave_gen;

  localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WRITE = 3'd2,
                         S_READ_ADD = 3'd3, S_READ_DATA = 3'd4, S_DONE = 3'd5;

  typedef struct {
    logic [9:0] d;
    logic [2:0] s;
  } rx_exp_t;

  logic        clk = 1'b0;
  logic        rst, ss_n, mosi, tx_valid;
  logic [7:0]  tx_data;
  logic        miso, rx_valid, frame_abort, tx_timeout;
  logic [9:0]  rx_data;
  logic [2:0]  cs;

  logic        ss_n16, mosi16, miso16, rx_valid16, abort16, tout16;
  logic [15:0] tx_data16;
  logic [17:0] rx_data16;
  logic [2:0]  cs16;

  int checks = 0;
  int errors = 0;

  rx_exp_t     rx_q[$];
  logic [17:0] rx16_q[$];
  logic        abort_q[$];
  logic        tout_q[$];
  logic        miso_q[$];

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_data(tx_data),
    .tx_valid(tx_valid), .MISO(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_abort(frame_abort), .tx_timeout(tx_timeout), .cs(cs)
  );

  spi_slave_gen_sva #(.DATA_W(8)) u_sva (
    .clk(clk), .rst(rst), .cs(cs), .rx_valid(rx_valid), .rx_data(rx_data),
    .MISO(miso), .frame_abort(frame_abort), .tx_timeout(tx_timeout)
  );

  spi_slave_gen #(.DATA_W(16), .TX_TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst), .SS_n(ss_n16), .MOSI(mosi16), .tx_data(tx_data16),
    .tx_valid(1'b0), .MISO(miso16), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .frame_abort(abort16), .tx_timeout(tout16), .cs(cs16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected strobe expected none (t=%0t)", nm, $time);
  endtask

  // Monitor: sampled 1 time unit after each active edge.
  always begin : monitor
    rx_exp_t e;
    logic    b;
    @(posedge clk);
    #1;
    if (rx_valid) begin
      if (rx_q.size() == 0) unexpected("rx_valid");
      else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.d));
        chk("rx_cs", 32'(cs), 32'(e.s));
      end
    end
    if (frame_abort) begin
      if (abort_q.size() == 0) unexpected("frame_abort");
      else begin
        void'(abort_q.pop_front());
        chk("abort_cs", 32'(cs), 32'(S_IDLE));
        chk("abort_miso", 32'(miso), 32'd0);
      end
    end
    if (tx_timeout) begin
      if (tout_q.size() == 0) unexpected("tx_timeout");
      else begin
        void'(tout_q.pop_front());
        chk("timeout_cs", 32'(cs), 32'(S_DONE));
      end
    end
    b = (miso_q.size() != 0) ? miso_q.pop_front() : 1'b0;
    chk("miso", 32'(miso), 32'(b));
    if (rx_valid16) begin
      if (rx16_q.size() == 0) unexpected("rx_valid16");
      else chk("rx_data16", 32'(rx_data16), 32'(rx16_q.pop_front()));
    end
    if (abort16) unexpected("frame_abort16");
    if (tout16)  unexpected("tx_timeout16");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Drives nbits of f MSB first; checks cs once the command bit has been taken.
  task automatic send8(input logic [9:0] f, input int nbits, input logic [2:0] cs_cmd);
    @(negedge clk) ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == 1) chk("cs_after_cmd", 32'(cs), 32'(cs_cmd));
      mosi = f[9-i];
    end
  endtask

  initial begin
    logic [7:0]  rd_word;
    logic [17:0] f16;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss_n16 = 1'b1; mosi16 = 1'b0; tx_data16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'(S_IDLE));
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    chk("rst_timeout", 32'(tx_timeout), 32'd0);
    chk("rst_cs16", 32'(cs16), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Write-data frame
    rx_q.push_back('{d: 10'h1A5, s: S_DONE});
    send8(10'h1A5, 10, S_WRITE);
    @(negedge clk);
    chk("write_cs", 32'(cs), 32'(S_DONE));
    mosi = 1'b1;
    @(negedge clk);
    chk("done_holds", 32'(cs), 32'(S_DONE));
    ss_n = 1'b1;
    @(negedge clk);
    chk("done_to_idle", 32'(cs), 32'(S_IDLE));

    // Reset in the middle of a write frame
    send8(10'h0FF, 4, S_WRITE);
    @(negedge clk) begin rst = 1'b1; ss_n = 1'b1; end
    @(negedge clk);
    chk("midrst_cs", 32'(cs), 32'(S_IDLE));
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Read address, then read data with tx handshake 3 cycles after rx_valid
    rx_q.push_back('{d: 10'h203, s: S_DONE});
    send8(10'h203, 10, S_READ_ADD);
    @(negedge clk) ss_n = 1'b1;
    @(negedge clk);
    rx_q.push_back('{d: 10'h3AA, s: S_READ_DATA});
    send8(10'h3AA, 10, S_READ_DATA);
    @(negedge clk);
    chk("rd_wait_cs", 32'(cs), 32'(S_READ_DATA));
    repeat (3) @(negedge clk);
    rd_word = 8'hC3;
    tx_data = rd_word; tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) miso_q.push_back(rd_word[i]);
    @(negedge clk) begin tx_valid = 1'b0; tx_data = '0; end
    @(negedge clk) begin tx_valid = 1'b1; tx_data = 8'hFF; end
    @(negedge clk) tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("shift_last_cs", 32'(cs), 32'(S_READ_DATA));
    @(negedge clk);
    chk("shift_end_cs", 32'(cs), 32'(S_DONE));
    ss_n = 1'b1;
    @(negedge clk);

    // rd_addr_seen was cleared: a read-data command lands in READ_ADD
    rx_q.push_back('{d: 10'h3FF, s: S_DONE});
    send8(10'h3FF, 10, S_READ_ADD);
    @(negedge clk) ss_n = 1'b1;
    @(negedge clk);

    // Read data with no tx_valid: timeout after 16 waiting cycles
    rx_q.push_back('{d: 10'h300, s: S_READ_DATA});
    tout_q.push_back(1'b1);
    send8(10'h300, 10, S_READ_DATA);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("tout_not_yet", 32'(tx_timeout), 32'd0);
    chk("tout_wait_cs", 32'(cs), 32'(S_READ_DATA));
    @(negedge clk);
    chk("tout_pulse", 32'(tx_timeout), 32'd1);
    chk("tout_cs", 32'(cs), 32'(S_DONE));
    ss_n = 1'b1;
    @(negedge clk);

    // Timeout also clears rd_addr_seen
    rx_q.push_back('{d: 10'h3C0, s: S_DONE});
    send8(10'h3C0, 10, S_READ_ADD);
    @(negedge clk) ss_n = 1'b1;
    @(negedge clk);

    // Abort after 5 bits of a write frame
    abort_q.push_back(1'b1);
    send8(10'h0F0, 5, S_WRITE);
    @(negedge clk) ss_n = 1'b1;
    @(negedge clk);
    chk("abort_cs_idle", 32'(cs), 32'(S_IDLE));
    chk("abort_rx_hold", 32'(rx_data), 32'h3C0);
    @(negedge clk);

    // Abort during the tx wait of a read-data frame
    rx_q.push_back('{d: 10'h355, s: S_READ_DATA});
    send8(10'h355, 10, S_READ_DATA);
    @(negedge clk);
    abort_q.push_back(1'b1);
    ss_n = 1'b1;
    @(negedge clk);
    chk("wait_abort_cs", 32'(cs), 32'(S_IDLE));
    @(negedge clk);

    // DATA_W=16 write frame
    f16 = 18'h1A5C3;
    rx16_q.push_back(f16);
    @(negedge clk) ss_n16 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk) mosi16 = f16[17-i];
    end
    @(negedge clk);
    chk("w16_cs", 32'(cs16), 32'(S_DONE));
    chk("w16_rx_data", 32'(rx_data16), 32'(f16));
    ss_n16 = 1'b1;
    repeat (4) @(negedge clk);

    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
    chk("rx16_q_drained", 32'(rx16_q.size()), 32'd0);
    chk("abort_q_drained", 32'(abort_q.size()), 32'd0);
    chk("tout_q_drained", 32'(tout_q.size()), 32'd0);
    chk("miso_q_drained", 32'(miso_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
